// File: rtl/crossword_pkg.sv
// ============================================================================
// Module   : crossword_pkg
// Brief    : Shared key classes, HID keycode constants and the key classifier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package crossword_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        ARROW   = 2'd1,
        LETTER  = 2'd2,
        CONTROL = 2'd3
    } key_class_t;

    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_BKSP  = 8'h2A;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_Z     = 8'h1D;

    typedef struct packed {
        logic [7:0] code;
        key_class_t cls;
        logic       rpt;
    } key_event_t;

    function automatic key_class_t classify_key(input logic [7:0] code);
        key_class_t cls;
        if (code >= KEY_A && code <= KEY_Z)
            cls = LETTER;
        else if (code >= KEY_RIGHT && code <= KEY_UP)
            cls = ARROW;
        else if (code == KEY_BKSP || code == KEY_ENTER)
            cls = CONTROL;
        else
            cls = NONE;
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_fifo.sv
// ============================================================================
// Module   : key_fifo
// Brief    : Show-ahead FIFO of key events; head is visible whenever non-empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_fifo
    import crossword_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  key_event_t i_data,
    input  logic       i_pop,
    output key_event_t o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    key_event_t       r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    // A push into a full FIFO is accepted only when the head leaves this cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_head = o_empty ? key_event_t'('0) : r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/key_event_gen.sv
// ============================================================================
// Module   : key_event_gen
// Brief    : Turns a held HID keycode level into classified press/repeat events.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_event_gen
    import crossword_pkg::*;
#(
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 6,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic [1:0] ev_class,
    output logic       ev_repeat,
    output logic [7:0] drop_cnt
);

    localparam int c_CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_DELAY_LAST = c_CNT_W'(REPEAT_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_RATE_LAST  = c_CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    state_t               r_state;
    logic [7:0]           r_kc_q;
    logic [7:0]           r_held;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [7:0]           r_drop_cnt;

    key_class_t           w_kc_cls;
    logic                 w_stable;
    logic                 w_release;
    logic                 w_pushable;
    logic                 w_new_key;
    logic                 w_rpt_key;
    logic                 w_push_rpt;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    key_event_t           w_push_ev;
    key_event_t           w_head;

    assign w_stable   = (keycode == r_kc_q);
    assign w_kc_cls   = classify_key(keycode);
    assign w_release  = w_stable && (w_kc_cls == NONE);
    assign w_pushable = w_stable && (w_kc_cls != NONE);
    assign w_new_key  = w_pushable && ((r_state == ST_IDLE) || (keycode != r_held));
    assign w_rpt_key  = (r_held == KEY_BKSP) || (classify_key(r_held) == ARROW);

    always_comb begin
        w_push_rpt = 1'b0;
        if (w_pushable && !w_new_key) begin
            if (r_state == ST_HOLD)
                w_push_rpt = w_rpt_key && (r_cnt == c_DELAY_LAST);
            else if (r_state == ST_REPEAT)
                w_push_rpt = (r_cnt == c_RATE_LAST);
        end
    end

    assign w_push    = w_new_key || w_push_rpt;
    assign w_push_ev = '{code: keycode, cls: w_kc_cls, rpt: w_push_rpt};

    // Unstable frames freeze the FSM so a single-frame glitch is invisible.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_kc_q  <= '0;
            r_held  <= '0;
            r_cnt   <= '0;
        end else begin
            r_kc_q <= keycode;
            if (w_release) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else if (w_new_key) begin
                r_state <= ST_HOLD;
                r_held  <= keycode;
                r_cnt   <= '0;
            end else if (w_push_rpt) begin
                r_state <= ST_REPEAT;
                r_cnt   <= '0;
            end else if (w_pushable) begin
                if (r_state == ST_HOLD && r_cnt != c_DELAY_LAST)
                    r_cnt <= r_cnt + c_CNT_W'(1);
                else if (r_state == ST_REPEAT)
                    r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign w_pop = ev_valid && ev_ready;

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n)
            r_drop_cnt <= '0;
        else if (w_push && w_full && !w_pop && r_drop_cnt != 8'hFF)
            r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    key_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_key_fifo (
        .clk     (frame_clk),
        .rst_n   (Reset_n),
        .i_push  (w_push),
        .i_data  (w_push_ev),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign ev_valid  = !w_empty;
    assign ev_code   = w_head.code;
    assign ev_class  = w_head.cls;
    assign ev_repeat = w_head.rpt;
    assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_key_event_gen.sv
// ============================================================================
// Module   : tb_key_event_gen
// Brief    : Randomized and directed self-checking bench for key_event_gen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_event_gen;

    localparam int D     = 30;
    localparam int R     = 6;
    localparam int DEPTH = 4;

    logic       frame_clk = 1'b0;
    logic       Reset_n   = 1'b0;
    logic [7:0] keycode   = 8'h00;
    logic       ev_ready  = 1'b1;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic [1:0] ev_class;
    logic       ev_repeat;
    logic [7:0] drop_cnt;

    always #5 frame_clk = ~frame_clk;

    key_event_gen #(
        .REPEAT_DELAY (D),
        .REPEAT_RATE  (R),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .keycode   (keycode),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_class  (ev_class),
        .ev_repeat (ev_repeat),
        .drop_cnt  (drop_cnt)
    );

    typedef struct {
        int code;
        int cls;
        int rpt;
        int t;
    } ev_t;

    ev_t m_q[$];
    ev_t obs[$];
    int  m_prev, m_held, m_since, m_reps, m_drop;
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    int  t0, s;
    int  codes [12] = '{0, 0, 8'h04, 8'h10, 8'h1D, 8'h4F, 8'h50, 8'h51, 8'h52, 8'h28, 8'h2A, 8'h30};

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int m_class(input int k);
        if (k >= 8'h04 && k <= 8'h1D) return 2;
        if (k >= 8'h4F && k <= 8'h52) return 1;
        if (k == 8'h28 || k == 8'h2A) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_prev  = 0;
        m_held  = -1;
        m_since = 0;
        m_reps  = 0;
        m_drop  = 0;
    endtask

    // Reference: counts stable frames since the last push of the held key.
    task automatic model_step();
        ev_t e;
        bit  push;
        int  kc, c;
        push = 1'b0;
        e    = '{0, 0, 0, 0};
        kc   = int'(keycode);
        if (kc == m_prev) begin
            c = m_class(kc);
            if (c == 0) begin
                m_held = -1;
            end else if (kc != m_held) begin
                push    = 1'b1;
                e       = '{kc, c, 0, 0};
                m_held  = kc;
                m_since = 0;
                m_reps  = 0;
            end else begin
                m_since++;
                if ((c == 1 || kc == 8'h2A) &&
                    ((m_reps == 0 && m_since == D) || (m_reps > 0 && m_since == R))) begin
                    push    = 1'b1;
                    e       = '{kc, c, 1, 0};
                    m_since = 0;
                    m_reps++;
                end
            end
        end
        m_prev = kc;
        if (m_q.size() > 0 && ev_ready)
            m_q.delete(0);
        if (push) begin
            if (m_q.size() < DEPTH)
                m_q.push_back(e);
            else if (m_drop < 255)
                m_drop++;
        end
    endtask

    task automatic compare();
        chk("ev_valid", int'(ev_valid), (m_q.size() > 0) ? 1 : 0);
        if (m_q.size() > 0) begin
            chk("ev_code", int'(ev_code), m_q[0].code);
            chk("ev_class", int'(ev_class), m_q[0].cls);
            chk("ev_repeat", int'(ev_repeat), m_q[0].rpt);
        end
        chk("drop_cnt", int'(drop_cnt), m_drop);
    endtask

    task automatic tick();
        if (ev_valid && ev_ready)
            obs.push_back('{int'(ev_code), int'(ev_class), int'(ev_repeat), cyc});
        model_step();
        @(posedge frame_clk);
        #1;
        cyc++;
        compare();
    endtask

    task automatic hold(input int code, input int n);
        keycode = 8'(code);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge frame_clk);
        #2 Reset_n = 1'b1;
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_code", int'(ev_code), 0);
        chk("rst_class", int'(ev_class), 0);
        chk("rst_repeat", int'(ev_repeat), 0);
        chk("rst_drop", int'(drop_cnt), 0);

        // Letter press: valid two edges after the change, exactly one event.
        obs.delete();
        keycode = 8'h04;
        tick();
        chk("letter_lat_edge0", int'(ev_valid), 0);
        tick();
        chk("letter_lat_edge1", int'(ev_valid), 1);
        chk("letter_code", int'(ev_code), 8'h04);
        chk("letter_class", int'(ev_class), 2);
        chk("letter_repeat", int'(ev_repeat), 0);
        hold(8'h04, 8);
        hold(0, 4);
        chk("letter_count", obs.size(), 1);

        // Arrow held 40 frames: press, repeat after 30, repeat after 6 more.
        obs.delete();
        t0 = cyc;
        hold(8'h4F, 40);
        hold(0, 4);
        chk("arrow_count", obs.size(), 3);
        if (obs.size() == 3) begin
            chk("arrow_press_time", obs[0].t - t0, 2);
            chk("arrow_gap1", obs[1].t - obs[0].t, 30);
            chk("arrow_gap2", obs[2].t - obs[1].t, 6);
            chk("arrow_rpt0", obs[0].rpt, 0);
            chk("arrow_rpt1", obs[1].rpt, 1);
            chk("arrow_rpt2", obs[2].rpt, 1);
            chk("arrow_class", obs[0].cls, 1);
        end

        // One-frame glitch.
        obs.delete();
        hold(8'h50, 1);
        hold(0, 5);
        chk("glitch_count", obs.size(), 0);
        chk("glitch_drop", int'(drop_cnt), 0);

        // Backspace with consumer stalled: 4 queued, 2 dropped, drains in order.
        ev_ready = 1'b0;
        hold(8'h2A, 60);
        hold(0, 3);
        chk("bksp_drop", int'(drop_cnt), 2);
        chk("bksp_valid", int'(ev_valid), 1);
        obs.delete();
        ev_ready = 1'b1;
        hold(0, 6);
        chk("bksp_drain_count", obs.size(), 4);
        foreach (obs[i]) begin
            chk("bksp_drain_code", obs[i].code, 8'h2A);
            chk("bksp_drain_class", obs[i].cls, 3);
            chk("bksp_drain_rpt", obs[i].rpt, (i == 0) ? 0 : 1);
        end

        // Switch keys mid-hold.
        obs.delete();
        hold(8'h51, 10);
        s = cyc;
        hold(8'h52, 10);
        hold(0, 4);
        chk("switch_count", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("switch_first_code", obs[0].code, 8'h51);
            chk("switch_second_code", obs[1].code, 8'h52);
            chk("switch_second_rpt", obs[1].rpt, 0);
            chk("switch_second_time", obs[1].t - s, 2);
        end

        // Asynchronous reset with events queued in REPEAT.
        ev_ready = 1'b0;
        hold(8'h4F, 40);
        chk("pre_reset_valid", int'(ev_valid), 1);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_reset_valid", int'(ev_valid), 0);
        chk("async_reset_drop", int'(drop_cnt), 0);
        model_reset();
        obs.delete();
        @(posedge frame_clk);
        #2 Reset_n = 1'b1;
        ev_ready = 1'b1;
        hold(8'h4F, 5);
        chk("post_reset_count", obs.size(), 1);
        if (obs.size() == 1) begin
            chk("post_reset_code", obs[0].code, 8'h4F);
            chk("post_reset_rpt", obs[0].rpt, 0);
        end
        hold(0, 4);

        // Drop counter saturation.
        ev_ready = 1'b0;
        hold(8'h52, 1600);
        chk("drop_saturated", int'(drop_cnt), 255);
        ev_ready = 1'b1;
        hold(0, 8);

        // Randomized key sequences against the model.
        #1 Reset_n = 1'b0;
        model_reset();
        @(posedge frame_clk);
        #2 Reset_n = 1'b1;
        for (int seg = 0; seg < 70; seg++) begin
            int n;
            keycode = 8'(codes[$urandom_range(0, 11)]);
            n = $urandom_range(1, 45);
            for (int i = 0; i < n; i++) begin
                ev_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
